router_pkt_fifo: RTL and testbench
==================================

ROUTER_PKT_FIFO -- requirements
Module: router_pkt_fifo

Interface
REQ-001 SHALL have parameter DW, default 8, data width in bits (min 4).
REQ-002 SHALL have parameter DEPTH, default 16, entry count (power of 2, min 4).
REQ-003 SHALL have parameter AF_MARGIN, default 2, free-entry threshold for almost_full (1..DEPTH-1).
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port sft_rst, input, 1, synchronous flush, active-high.
REQ-007 SHALL have port wr_en, input, 1, write request.
REQ-008 SHALL have port din, input, DW, write data.
REQ-009 SHALL have port lfd_state, input, 1, header marker; high in the cycle before the header byte is written.
REQ-010 SHALL have port rd_en, input, 1, read request.
REQ-011 SHALL have port dout, output, DW, registered read data.
REQ-012 SHALL have port dout_valid, output, 1, dout updated by a read this cycle.
REQ-013 SHALL have port full, empty, almost_full, output, 1 each, occupancy flags.
REQ-014 SHALL have port count, output, log2(DEPTH)+1, current occupancy.
REQ-015 SHALL have port pkt_done, output, 1, one-cycle pulse when last byte of a packet is read.
REQ-016 SHALL have port wr_err, output, 1, one-cycle pulse on write attempt while full.

Function
REQ-017 SHALL store DW+1 bits per entry: {hdr_tag, din}, hdr_tag = lfd_state registered one cycle.
REQ-018 SHALL accept a write iff wr_en && !full; SHALL accept a read iff rd_en && !empty; both SHALL complete in the same cycle.
REQ-019 SHALL use log2(DEPTH)+1-bit pointers; full = addresses equal, MSBs differ; empty = pointers equal; wrap is natural modulo 2*DEPTH.
REQ-020 SHALL update count +1 write-only, -1 read-only, unchanged on simultaneous accepted write+read.
REQ-021 SHALL reject a write when full even if a read is accepted in the same cycle; wr_err pulses next cycle.
REQ-022 SHALL assert almost_full when count >= DEPTH-AF_MARGIN.
REQ-023 SHALL present read data on dout one cycle after the accepted read, with dout_valid high that cycle; otherwise dout holds last value, dout_valid low; dout never tri-stated.
REQ-024 SHALL keep an internal byte-remaining counter, width DW-1: on reading a hdr_tag=1 entry, load din[DW-1:2]+1 (payload plus parity); on reading a hdr_tag=0 entry with counter nonzero, decrement.
REQ-025 SHALL pulse pkt_done the cycle dout_valid shows the byte that takes the counter from 1 to 0.
REQ-026 SHALL treat a header read while counter nonzero as a new packet: reload counter, no pkt_done for the truncated packet.
REQ-027 SHALL ignore rd_en when empty and wr_en when full without pointer, count or memory change.

Reset
REQ-028 SHALL on rst: pointers, count, byte counter, hdr register = 0; dout = 0; dout_valid, pkt_done, wr_err = 0; empty = 1, full = 0, almost_full = 0.
REQ-029 SHALL on sft_rst (rst low): same as REQ-028 in the following cycle, overriding any same-cycle read or write; memory contents need not be cleared.
REQ-030 SHALL give rst priority over sft_rst, sft_rst priority over wr_en/rd_en.

Structure
REQ-031 SHALL place DW default, header length field bounds (bits DW-1:2) and an address-width function in shared package router_pkg.
REQ-032 SHALL implement storage as sub-module router_fifo_mem (synchronous-write, one read port, no reset); pointers, flags and packet tracking stay in router_pkt_fifo.

Verification
REQ-033 Reset then write 16 bytes, no reads (DW=8, DEPTH=16) -> full=1 after 16th, count=16, almost_full from count=14; 17th write -> wr_err pulse, count unchanged.
REQ-034 Header 0x0C (length 3) with lfd_state, then 3 payload bytes + parity; read all 5 -> dout sequence 0x0C,payload,parity each with dout_valid; pkt_done pulses exactly with the parity byte.
REQ-035 Count=8, simultaneous wr_en+rd_en for 20 cycles -> count stays 8, data order preserved across pointer wrap.
REQ-036 Count=16 (full), wr_en+rd_en same cycle -> read accepted, write rejected, wr_err pulse, count=15.
REQ-037 sft_rst mid-packet after 3 of 6 bytes read -> next cycle empty=1, count=0, dout=0; subsequent new header packet of length 1 reads 3 bytes with pkt_done on third.
REQ-038 rd_en on empty for 4 cycles -> dout_valid stays 0, dout holds, pointers unchanged.

Source files
------------

// File: rtl/router_pkg.sv
// Shared constants and helpers for the router packet FIFO: default data width,
// header length field position and address-width calculation.
package router_pkg;

    localparam int ROUTER_DW   = 8;
    localparam int HDR_LEN_LSB = 2;

    function automatic int hdr_len_msb(input int dw);
        return dw - 1;
    endfunction

    function automatic int addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// FIFO storage array: synchronous write, combinational single read port, no reset.
module router_fifo_mem
    import router_pkg::*;
#(
    parameter int WIDTH = ROUTER_DW + 1,
    parameter int DEPTH = 16
) (
    input  logic                           clk,
    input  logic                           wr_en,
    input  logic [addr_width(DEPTH)-1:0]   wr_addr,
    input  logic [WIDTH-1:0]               wr_data,
    input  logic [addr_width(DEPTH)-1:0]   rd_addr,
    output logic [WIDTH-1:0]               rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/router_pkt_fifo.sv
// Router output FIFO: stores header-tagged bytes, registers read data and
// tracks packet boundaries to pulse pkt_done on the final (parity) byte.
module router_pkt_fifo
    import router_pkg::*;
#(
    parameter int DW        = ROUTER_DW,
    parameter int DEPTH     = 16,
    parameter int AF_MARGIN = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sft_rst,
    input  logic                          wr_en,
    input  logic [DW-1:0]                 din,
    input  logic                          lfd_state,
    input  logic                          rd_en,
    output logic [DW-1:0]                 dout,
    output logic                          dout_valid,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic [addr_width(DEPTH):0]    count,
    output logic                          pkt_done,
    output logic                          wr_err
);

    localparam int            AW       = addr_width(DEPTH);
    localparam int            LEN_MSB  = hdr_len_msb(DW);
    localparam int            CW       = DW - 1;
    localparam logic [AW:0]   AF_LEVEL = (AW+1)'(DEPTH - AF_MARGIN);

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [CW-1:0] byte_cnt_q, byte_cnt_d;
    logic          hdr_q, hdr_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          dout_valid_q, dout_valid_d;
    logic          pkt_done_q, pkt_done_d;
    logic          wr_err_q, wr_err_d;

    logic          wr_acc, rd_acc, mem_wr_en;
    logic [DW:0]   rd_entry;
    logic          rd_tag;
    logic [DW-1:0] rd_byte;

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    // A write is refused when full even if a read frees a slot this same cycle.
    assign wr_acc    = wr_en && !full;
    assign rd_acc    = rd_en && !empty;
    assign mem_wr_en = wr_acc && !sft_rst;

    assign rd_tag  = rd_entry[DW];
    assign rd_byte = rd_entry[DW-1:0];

    router_fifo_mem #(
        .WIDTH (DW + 1),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (mem_wr_en),
        .wr_addr (wr_ptr_q[AW-1:0]),
        .wr_data ({hdr_q, din}),
        .rd_addr (rd_ptr_q[AW-1:0]),
        .rd_data (rd_entry)
    );

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        byte_cnt_d   = byte_cnt_q;
        hdr_d        = lfd_state;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        pkt_done_d   = 1'b0;
        wr_err_d     = wr_en && full;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (rd_acc) begin
            rd_ptr_d     = rd_ptr_q + 1'b1;
            dout_d       = rd_byte;
            dout_valid_d = 1'b1;
            // A header always restarts the count, silently dropping any truncated packet.
            if (rd_tag) begin
                byte_cnt_d = CW'(rd_byte[LEN_MSB:HDR_LEN_LSB]) + CW'(1);
            end else if (byte_cnt_q != '0) begin
                byte_cnt_d = byte_cnt_q - 1'b1;
                pkt_done_d = (byte_cnt_q == CW'(1));
            end
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (sft_rst) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            byte_cnt_d   = '0;
            hdr_d        = 1'b0;
            dout_d       = '0;
            dout_valid_d = 1'b0;
            pkt_done_d   = 1'b0;
            wr_err_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            byte_cnt_q   <= '0;
            hdr_q        <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            pkt_done_q   <= 1'b0;
            wr_err_q     <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            byte_cnt_q   <= byte_cnt_d;
            hdr_q        <= hdr_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            pkt_done_q   <= pkt_done_d;
            wr_err_q     <= wr_err_d;
        end
    end

    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;
    assign pkt_done    = pkt_done_q;
    assign wr_err      = wr_err_q;
    assign count       = count_q;
    assign almost_full = (count_q >= AF_LEVEL);

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Directed bench for router_pkt_fifo with a queue-based reference model that
// predicts every output each cycle.
module tb_router_pkt_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AFM   = 2;
    localparam int CNTW  = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            sft_rst = 1'b0;
    logic            wr_en = 1'b0;
    logic [DW-1:0]   din = '0;
    logic            lfd_state = 1'b0;
    logic            rd_en = 1'b0;
    logic [DW-1:0]   dout;
    logic            dout_valid, full, empty, almost_full, pkt_done, wr_err;
    logic [CNTW-1:0] count;

    always #5 clk = ~clk;

    router_pkt_fifo #(.DW(DW), .DEPTH(DEPTH), .AF_MARGIN(AFM)) dut (
        .clk         (clk),
        .rst         (rst),
        .sft_rst     (sft_rst),
        .wr_en       (wr_en),
        .din         (din),
        .lfd_state   (lfd_state),
        .rd_en       (rd_en),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .count       (count),
        .pkt_done    (pkt_done),
        .wr_err      (wr_err)
    );

    logic [DW:0]   sb_q[$];
    logic          m_hdr = 1'b0;
    int            m_bc = 0;
    logic [DW-1:0] m_dout = '0;
    int            n_pass = 0;
    int            n_total = 0;
    string         step = "init";

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s/%s observed=0x%0h expected=0x%0h", step, tag, obs, exp);
    endtask

    // One clock: drive inputs, advance the model, then check every output at negedge.
    task automatic cyc(input logic r, input logic s, input logic w, input logic [DW-1:0] d,
                       input logic l, input logic rd);
        logic        exp_rd, exp_wr, exp_err, exp_pd;
        logic [DW:0] e;
        rst = r; sft_rst = s; wr_en = w; din = d; lfd_state = l; rd_en = rd;
        exp_rd = 1'b0; exp_wr = 1'b0; exp_err = 1'b0; exp_pd = 1'b0;
        if (r || s) begin
            sb_q.delete();
            m_bc = 0; m_hdr = 1'b0; m_dout = '0;
        end else begin
            exp_rd  = rd && (sb_q.size() > 0);
            exp_wr  = w && (sb_q.size() < DEPTH);
            exp_err = w && (sb_q.size() == DEPTH);
            if (exp_rd) begin
                e = sb_q.pop_front();
                m_dout = e[DW-1:0];
                if (e[DW]) begin
                    m_bc = int'(e[DW-1:2]) + 1;
                end else if (m_bc != 0) begin
                    exp_pd = (m_bc == 1);
                    m_bc--;
                end
            end
            if (exp_wr) sb_q.push_back({m_hdr, d});
            m_hdr = l;
        end
        @(posedge clk);
        @(negedge clk);
        chk("dout_valid", 32'(dout_valid), 32'(exp_rd));
        chk("dout", 32'(dout), 32'(m_dout));
        chk("pkt_done", 32'(pkt_done), 32'(exp_pd));
        chk("wr_err", 32'(wr_err), 32'(exp_err));
        chk("count", 32'(count), 32'(sb_q.size()));
        chk("empty", 32'(empty), 32'(sb_q.size() == 0));
        chk("full", 32'(full), 32'(sb_q.size() == DEPTH));
        chk("almost_full", 32'(almost_full), 32'(sb_q.size() >= DEPTH - AFM));
    endtask

    task automatic wr(input logic [DW-1:0] d, input logic l);
        cyc(1'b0, 1'b0, 1'b1, d, l, 1'b0);
    endtask

    task automatic rd1();
        cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic idle(input logic l);
        cyc(1'b0, 1'b0, 1'b0, '0, l, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) rd1();
    endtask

    initial begin
        @(negedge clk);
        step = "reset";
        cyc(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b1);
        idle(1'b0);

        step = "fill";
        for (int i = 0; i < DEPTH; i++) wr(DW'(8'h30 + i), 1'b0);
        chk("full_after_16", 32'(full), 32'd1);
        wr(8'hEE, 1'b0);
        chk("count_after_17th", 32'(count), 32'd16);
        chk("wr_err_17th", 32'(wr_err), 32'd1);
        idle(1'b0);
        chk("wr_err_one_pulse", 32'(wr_err), 32'd0);
        step = "fill_drain";
        drain(DEPTH);

        step = "packet";
        idle(1'b1);
        wr(8'h0C, 1'b0);
        wr(8'h11, 1'b0);
        wr(8'h22, 1'b0);
        wr(8'h33, 1'b0);
        wr(8'h5A, 1'b0);
        drain(4);
        chk("no_done_before_parity", 32'(pkt_done), 32'd0);
        rd1();
        chk("done_with_parity", 32'(pkt_done), 32'd1);
        chk("parity_byte", 32'(dout), 32'h5A);
        idle(1'b0);

        step = "truncated";
        idle(1'b1);
        wr(8'h0C, 1'b0);
        wr(8'h41, 1'b1);
        wr(8'h04, 1'b0);
        wr(8'h42, 1'b0);
        wr(8'h43, 1'b0);
        drain(5);

        step = "simul_wrap";
        for (int i = 0; i < 8; i++) wr(DW'(8'h80 + i), 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b1, DW'(8'h90 + i), 1'b0, 1'b1);
        chk("count_held_8", 32'(count), 32'd8);
        drain(8);

        step = "full_wr_rd";
        for (int i = 0; i < DEPTH; i++) wr(DW'(8'hC0 + i), 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1);
        chk("count_15", 32'(count), 32'd15);
        chk("wr_err_full_rd", 32'(wr_err), 32'd1);
        drain(15);
        idle(1'b0);

        step = "sft_rst";
        idle(1'b1);
        wr(8'h10, 1'b0);
        for (int i = 0; i < 5; i++) wr(DW'(8'h61 + i), 1'b0);
        drain(3);
        cyc(1'b0, 1'b1, 1'b1, 8'h77, 1'b0, 1'b1);
        chk("sft_empty", 32'(empty), 32'd1);
        chk("sft_dout", 32'(dout), 32'd0);
        idle(1'b1);
        wr(8'h04, 1'b0);
        wr(8'h71, 1'b0);
        wr(8'h72, 1'b0);
        drain(2);
        rd1();
        chk("len1_done_third", 32'(pkt_done), 32'd1);

        step = "rd_empty";
        for (int i = 0; i < 4; i++) rd1();
        chk("hold_dout", 32'(dout), 32'h72);
        wr(8'h3C, 1'b0);
        rd1();
        chk("after_empty_reads", 32'(dout), 32'h3C);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
